// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU/memory types (RAM handshake, data word, arbiter FSM state)
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction/data) arbiter in front of the variable-latency RAM; `define MEMARB_RR_EN for round-robin ties
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  ramstate_t         ramstate,
    output logic              arb_err
);

    arb_state_t state;
    logic       dreq, ack, i_srv, d_srv, pick_d;

    assign dreq  = dREN || dWEN;
    assign ack   = ramstate == ACCESS;
    assign i_srv = state == IGNT && iREN && ack;
    assign d_srv = state == DGNT && dreq && ack;

`ifdef MEMARB_RR_EN
    logic last_d;

    // remember which side was served last so a tie goes to the other one
    always_ff @(posedge CLK) begin
        if (RST)
            last_d <= 1'b0;
        else if (i_srv || d_srv)
            last_d <= d_srv;
    end

    assign pick_d = dreq && (!iREN || !last_d);
`else
    assign pick_d = dreq;
`endif

    // grant FSM plus sticky RAM error flag; a served or abandoned grant always passes through IDLE
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            arb_err <= 1'b0;
        end else begin
            if (state != IDLE && ramstate == ERROR)
                arb_err <= 1'b1;
            state <= state == IDLE ? (pick_d ? DGNT : iREN ? IGNT : IDLE) :
                     state == IGNT ? (!iREN || ack ? IDLE : IGNT) :
                                     (!dreq || ack ? IDLE : DGNT);
        end
    end

    // RAM bus follows the live requester inputs so address changes mid-grant reach the RAM at once
    assign ramREN   = state == IGNT || (state == DGNT && !dWEN);
    assign ramWEN   = state == DGNT && dWEN;
    assign ramaddr  = state == IGNT ? iaddr : state == DGNT ? daddr : '0;
    assign ramstore = state == DGNT ? dstore : '0;

    assign iwait = !i_srv;
    assign iload = i_srv ? ramload : '0;
    assign dwait = !d_srv;
    assign dload = d_srv && !dWEN ? ramload : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with an emulated variable-latency RAM
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    typedef struct {
        bit          side;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
    logic        iwait, dwait, ramREN, ramWEN, arb_err;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [31:0] ramload = '0;
    ramstate_t   ramstate;

    int          checks = 0, failures = 0;
    int          icnt = 0, dcnt = 0;
    int          lat = 1, cnt = 0;
    bit          force_err = 1'b0, gap = 1'b0;
    logic [33:0] last_key = '0, cur_key;
    logic [31:0] ram_mem [int];
    logic [31:0] ref_mem [int];
    exp_t        sb [$];
`ifdef MEMARB_RR_EN
    bit          m_last_d = 1'b0;
`endif

    mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
    );

    always #5 CLK = ~CLK;

    function automatic int ix(logic [31:0] a);
        return int'(a[15:2]);
    endfunction

    function automatic logic [31:0] dflt(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] ram_rd(int i);
        return ram_mem.exists(i) ? ram_mem[i] : dflt(i);
    endfunction

    function automatic logic [31:0] ref_rd(int i);
        return ref_mem.exists(i) ? ref_mem[i] : dflt(i);
    endfunction

    task automatic chk(string n, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    // emulated RAM: access completes after lat cycles of an unchanged request
    assign cur_key = {ramREN, ramWEN, ramaddr};
    always_comb
        ramstate = force_err ? ERROR : !(ramREN || ramWEN) ? FREE :
                   (cur_key == last_key && cnt >= lat) ? ACCESS : BUSY;

    always @(posedge CLK) begin
        if (ramstate == ACCESS && ramWEN)
            ram_mem[ix(ramaddr)] = ramstore;
        ramload  <= ram_rd(ix(ramaddr));
        cnt      <= (ramREN || ramWEN) ? (cur_key == last_key ? cnt + 1 : 1) : 0;
        last_key <= cur_key;
    end

    // monitor: every served cycle pops the next expected transaction
    always @(negedge CLK) begin
        exp_t e;
        if (gap)
            chk("idle_gap_enables", {ramREN, ramWEN}, 2'b00);
        gap = 1'b0;
        if (iREN && !iwait) begin
            gap = 1'b1;
            icnt++;
            if (sb.size() == 0)
                chk("unexpected_i_serve", 1, 0);
            else begin
                e = sb.pop_front();
                chk("i_serve_side", 0, e.side);
                chk("i_ramaddr", ramaddr, e.addr);
                chk("iload", iload, e.data);
            end
        end
        if ((dREN || dWEN) && !dwait) begin
            gap = 1'b1;
            dcnt++;
            if (sb.size() == 0)
                chk("unexpected_d_serve", 1, 0);
            else begin
                e = sb.pop_front();
                chk("d_serve_side", 1, e.side);
                chk("d_ramaddr", ramaddr, e.addr);
                if (e.wr) begin
                    chk("d_wr_enables", {ramWEN, ramREN}, 2'b10);
                    chk("d_ramstore", ramstore, e.data);
                end else
                    chk("dload", dload, e.data);
            end
        end
    end

    // reference model: one served transaction in arrival order
    task automatic mod_i(logic [31:0] a);
        sb.push_back('{side: 1'b0, wr: 1'b0, addr: a, data: ref_rd(ix(a))});
`ifdef MEMARB_RR_EN
        m_last_d = 1'b0;
`endif
    endtask

    task automatic mod_d(bit w, logic [31:0] a, logic [31:0] s);
        if (w) begin
            ref_mem[ix(a)] = s;
            sb.push_back('{side: 1'b1, wr: 1'b1, addr: a, data: s});
        end else
            sb.push_back('{side: 1'b1, wr: 1'b0, addr: a, data: ref_rd(ix(a))});
`ifdef MEMARB_RR_EN
        m_last_d = 1'b1;
`endif
    endtask

    task automatic episode(bit ui, bit ud, bit dw, bit dr, logic [31:0] ia, logic [31:0] da,
                           logic [31:0] ds, int l);
        bit dfirst;
        int i0, d0;
        @(posedge CLK);
        #1;
        lat = l; iaddr = ia; daddr = da; dstore = ds;
        iREN = ui; dWEN = ud && dw; dREN = ud && dr;
        i0 = icnt; d0 = dcnt;
`ifdef MEMARB_RR_EN
        dfirst = !m_last_d;
`else
        dfirst = 1'b1;
`endif
        if (ud && (dfirst || !ui)) begin
            mod_d(dw, da, ds);
            if (ui) mod_i(ia);
        end else begin
            if (ui) mod_i(ia);
            if (ud) mod_d(dw, da, ds);
        end
        for (int t = 0; t < 100; t++) begin
            @(posedge CLK);
            #1;
            if (icnt != i0) iREN = 1'b0;
            if (dcnt != d0) begin dREN = 1'b0; dWEN = 1'b0; end
            if (!iREN && !dREN && !dWEN) break;
        end
        if (iREN || dREN || dWEN) begin
            chk("episode_timeout", 1, 0);
            iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
            sb.delete();
        end
    endtask

    function automatic logic [31:0] raddr();
        return ($urandom() & 32'hFFFF_0000) | 32'h100 | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_waits", {iwait, dwait}, 2'b11);
        chk("rst_enables", {ramREN, ramWEN}, 2'b00);
        chk("rst_ramaddr", ramaddr, 0);
        chk("rst_ramstore", ramstore, 0);
        chk("rst_loads", {iload, dload}, 64'd0);
        chk("rst_arb_err", arb_err, 0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // fetch with latency 10: RAM driven from cycle 1, served on cycle 11
        @(posedge CLK);
        #1;
        ram_mem[ix(32'h40)] = 32'hDEAD_BEEF;
        ref_mem[ix(32'h40)] = 32'hDEAD_BEEF;
        lat = 10; iaddr = 32'h40; iREN = 1'b1;
        mod_i(32'h40);
        @(negedge CLK);
        chk("fetch_c0_ramREN", ramREN, 0);
        for (int c = 1; c <= 11; c++) begin
            @(negedge CLK);
            if (c == 1) chk("fetch_c1_ramREN", ramREN, 1);
            if (c == 10) chk("fetch_c10_iwait", iwait, 1);
            if (c == 11) begin
                chk("fetch_c11_iwait", iwait, 0);
                chk("fetch_c11_iload", iload, 32'hDEAD_BEEF);
            end
        end
        @(posedge CLK);
        #1 iREN = 1'b0;
        @(negedge CLK);
        chk("fetch_c12_ramREN", ramREN, 0);

        // simultaneous fetch and write, then write with both enables
        episode(1, 1, 1, 0, 32'h140, 32'h100, 32'h1234_5678, 3);
        chk("ram_word_0x100", ram_mem[ix(32'h100)], 32'h1234_5678);
        for (int k = 0; k < 3; k++)
            episode(1, 1, 1, 0, raddr(), raddr(), $urandom(), $urandom_range(1, 4));
        episode(0, 1, 1, 1, 0, 32'h200, 32'hCAFE_F00D, 4);
        chk("wr_both_en_arb_err", arb_err, 0);

        // fetch abandoned three cycles into its grant
        @(posedge CLK);
        #1 lat = 10; iaddr = 32'h80; iREN = 1'b1;
        repeat (4) @(posedge CLK);
        #1 iREN = 1'b0;
        @(negedge CLK);
        chk("abort_c4_iwait", iwait, 1);
        @(negedge CLK);
        chk("abort_c5_enables", {ramREN, ramWEN}, 2'b00);
        chk("abort_c5_iwait", iwait, 1);
        chk("abort_arb_err", arb_err, 0);

        // reset in the middle of a data write grant
        @(posedge CLK);
        #1 lat = 10; daddr = 32'h300; dstore = 32'h5555_AAAA; dWEN = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("wr_grant_enables", {ramWEN, ramREN}, 2'b10);
        repeat (4) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_enables", {ramREN, ramWEN}, 2'b00);
        chk("midrst_bus", {ramaddr, ramstore}, 64'd0);
        chk("midrst_dwait", dwait, 1);
        dWEN = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
`ifdef MEMARB_RR_EN
        m_last_d = 1'b0;
`endif
        chk("midrst_no_write", ram_mem.exists(ix(32'h300)), 0);

        // RAM error during a grant: sticky flag, grant still completes
        fork
            episode(1, 0, 0, 0, 32'h104, 0, 0, 6);
            begin
                repeat (4) @(posedge CLK);
                #1 force_err = 1'b1;
                @(posedge CLK);
                #1 force_err = 1'b0;
                @(negedge CLK);
                chk("err_set", arb_err, 1);
            end
        join
        repeat (3) @(posedge CLK);
        #1 chk("err_sticky", arb_err, 1);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
`ifdef MEMARB_RR_EN
        m_last_d = 1'b0;
`endif
        chk("err_cleared", arb_err, 0);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            int  k;
            bit  w;
            k = $urandom_range(0, 3);
            w = 1'($urandom_range(0, 1));
            episode(k == 0 || k == 3, k != 0, w, !w || 1'($urandom_range(0, 1)),
                    raddr(), raddr(), $urandom(), $urandom_range(1, 6));
        end
        repeat (3) @(posedge CLK);
        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
